down_counter_reload: RTL and testbench
======================================

Name: down_counter_reload

Overview:
- Loadable down-counter: the count-down counterpart of the team's up-counters.
- Accepts a start value over a valid/ready load handshake, then decrements by STRIDE on each enabled cycle.
- Signals terminal count with a one-cycle done pulse and a sticky underflow flag.
- Used in the arch-sweep datapath as a bitstream-length / epoch timer, the consumer-side complement of the accumulating counters.

Parameters:
WIDTH, 4, bit width of the count and load value
STRIDE, 1, decrement per enabled cycle; legal range 1 .. 2^WIDTH-1

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  load request
load_ready  output  1  high only in IDLE; load accepted when load_valid & load_ready
load_value  input  WIDTH  start value, captured on accept
en  input  1  decrement enable, honoured only in RUN
abort  input  1  cancel an active count, honoured only in RUN
countval  output  WIDTH  current count (registered)
busy  output  1  high in RUN
done  output  1  high exactly while in DONE (one-cycle pulse)
underflow  output  1  sticky: final decrement had a nonzero remainder

Behaviour:
- Reset (rst_n=0, async): state=IDLE, countval=0, underflow=0, done=0, busy=0, load_ready=1. Takes effect immediately, also mid-RUN; no done is produced.
- States: IDLE, RUN, DONE. Outputs decode from registered state, so there is no combinational in-to-out path.
- IDLE:
  - On load_valid at an edge: countval<=load_value, underflow<=0.
  - Next state is RUN if load_value!=0, else DONE (zero load gives done on the next cycle, underflow=0).
  - en and abort are ignored.
- RUN, evaluated in priority order:
  - abort=1: countval<=0, state<=IDLE, no done pulse, underflow unchanged. abort wins over a simultaneous en.
  - en=1 and countval>STRIDE: countval<=countval-STRIDE, stay in RUN.
  - en=1 and countval<=STRIDE: countval<=0, state<=DONE, underflow<=(countval!=STRIDE). The count never wraps below 0.
  - en=0: hold.
- load_valid in RUN or DONE is ignored (load_ready=0); the requester must hold load_valid until accepted.
- DONE: done=1 for one cycle, then IDLE unconditionally (absent the optional feature).
- Latency: with accept at edge E0 and load_value = N*STRIDE (N>=1), done is high in the cycle following the Nth enabled edge in RUN.
- Arithmetic:
  - Subtraction is WIDTH bits; the comparison above guarantees no negative result.
  - load_value=2^WIDTH-1 with STRIDE=1 takes 2^WIDTH-1 enabled cycles.

Optional Feature:
- Macro DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - Adds input port reload_en (1 bit) and a WIDTH-bit reload register.
  - The reload register is written with load_value on every accepted load and reset to 0.
  - In DONE with reload_en=1 and reload register !=0: done still pulses, countval<=reload register, next state RUN (not IDLE), underflow is retained.
  - reload_en=0 or reload register=0: behaves as without the macro.
  - abort in RUN still returns to IDLE.
- Undefined: no reload_en port, no reload register; DONE always goes to IDLE.

Test Plan:
- WIDTH=4, STRIDE=1, load 5, en held 1 -> countval 5,4,3,2,1,0 on successive cycles. done high one cycle right after countval reaches 0, busy low in that cycle, underflow=0, load_ready=1 the cycle after.
- WIDTH=4, STRIDE=4, load 10, en held 1 -> countval 10,6,2,0; done after the 3rd enabled edge; underflow=1. A reload of 8 then gives 8,4,0 with underflow cleared to 0 on accept.
- Load 9, STRIDE=1, en toggled 1,0,1,0 -> countval holds on en=0 cycles. abort asserted together with en at countval=7 -> IDLE, countval=0, no done, load_ready=1.
- load_value=0 -> done next cycle, busy never high, countval=0. load_valid held during RUN -> load_ready=0, countval unaffected.
- rst_n pulsed low mid-RUN at countval=3 -> immediately countval=0, busy=0, done=0, underflow=0, load_ready=1 before the next clock edge.
- With DOWN_COUNTER_AUTO_RELOAD_EN, load 3, STRIDE=1, reload_en=1, en held 1 -> periodic done every 3 enabled cycles (3,2,1,0,3,2,1,0,...). Drop reload_en -> final done, then IDLE.

Source files
------------

// File: rtl/down_counter_reload.sv
// down_counter_reload
//   Loadable down-counter used as a bitstream-length / epoch timer.
//   A start value is accepted over a valid/ready handshake while idle. The
//   counter then decrements by STRIDE on every enabled cycle and reports
//   terminal count with a one-cycle done pulse. A sticky underflow flag
//   records whether the last decrement overshot zero.
//
//   Optional build macro: DOWN_COUNTER_AUTO_RELOAD_EN
//     Adds the reload_en input and a reload register holding the last
//     accepted load value. With reload_en high, DONE restarts the count
//     from that register instead of returning to IDLE.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a load; load_ready high, countval parked at 0
//   RUN   | counting down on en; abort returns to IDLE without done
//   DONE  | terminal count reached; done high for exactly this cycle
module down_counter_reload #(
  parameter int WIDTH  = 4,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             abort,
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  input  logic             reload_en,
`endif
  output logic [WIDTH-1:0] countval,
  output logic             busy,
  output logic             done,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] STRIDE_W = WIDTH'(STRIDE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_ready_q, load_ready_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state and next-count computation; status outputs are derived from
  // the next state so they can be registered alongside it.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    underflow_d = underflow_q;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d    = reload_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          count_d     = load_value;
          underflow_d = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          reload_d    = load_value;
`endif
          // A zero load has nothing to count, so go straight to DONE.
          state_d     = (load_value != '0) ? ST_RUN : ST_DONE;
        end
      end

      ST_RUN: begin
        if (abort) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (en) begin
          if (count_q > STRIDE_W) begin
            count_d = count_q - STRIDE_W;
          end else begin
            // Clamp at zero instead of wrapping; note any leftover.
            count_d     = '0;
            underflow_d = (count_q != STRIDE_W);
            state_d     = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        if (reload_en && (reload_q != '0)) begin
          count_d = reload_q;
          state_d = ST_RUN;
        end
`endif
      end

      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d       = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
    load_ready_d = (state_d == ST_IDLE);
  end

  // State, count and status registers; reset parks the block in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      underflow_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      underflow_q  <= underflow_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q     <= reload_d;
`endif
    end
  end

  assign countval   = count_q;
  assign underflow  = underflow_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed bench for down_counter_reload: one instance with STRIDE=1 (a_*)
// and one with STRIDE=4 (b_*), both WIDTH=4, sharing clock and reset.
module tb_down_counter_reload;

  logic       clk;
  logic       rst_n;

  logic       a_load_valid, a_load_ready, a_en, a_abort, a_busy, a_done, a_underflow;
  logic [3:0] a_load_value, a_countval;
  logic       b_load_valid, b_load_ready, b_en, b_abort, b_busy, b_done, b_underflow;
  logic [3:0] b_load_value, b_countval;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic       a_reload_en, b_reload_en;
`endif

  int errors = 0;
  int checks = 0;

  down_counter_reload #(.WIDTH(4), .STRIDE(1)) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (a_load_valid),
    .load_ready (a_load_ready),
    .load_value (a_load_value),
    .en         (a_en),
    .abort      (a_abort),
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    .reload_en  (a_reload_en),
`endif
    .countval   (a_countval),
    .busy       (a_busy),
    .done       (a_done),
    .underflow  (a_underflow)
  );

  down_counter_reload #(.WIDTH(4), .STRIDE(4)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (b_load_valid),
    .load_ready (b_load_ready),
    .load_value (b_load_value),
    .en         (b_en),
    .abort      (b_abort),
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    .reload_en  (b_reload_en),
`endif
    .countval   (b_countval),
    .busy       (b_busy),
    .done       (b_done),
    .underflow  (b_underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if (a_countval !== 4'd0) begin errors++; $display("FAIL reset_countval got %0d exp 0", a_countval); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", a_done); end
    checks++; if (a_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", a_underflow); end
    checks++; if (a_load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", a_load_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_countdown();
    a_load_valid = 1'b1; a_load_value = 4'd5; a_en = 1'b1;
    step();
    a_load_valid = 1'b0;
    checks++; if (a_countval !== 4'd5) begin errors++; $display("FAIL basic_accept countval got %0d exp 5", a_countval); end
    checks++; if (a_busy !== 1'b1 || a_load_ready !== 1'b0) begin errors++; $display("FAIL basic_accept busy/ready got %b/%b exp 1/0", a_busy, a_load_ready); end
    for (int i = 4; i >= 1; i--) begin
      step();
      checks++; if (a_countval !== 4'(i) || a_done !== 1'b0) begin errors++; $display("FAIL basic_count countval/done got %0d/%b exp %0d/0", a_countval, a_done, i); end
    end
    step();
    checks++; if (a_countval !== 4'd0 || a_done !== 1'b1) begin errors++; $display("FAIL basic_done countval/done got %0d/%b exp 0/1", a_countval, a_done); end
    checks++; if (a_busy !== 1'b0 || a_underflow !== 1'b0) begin errors++; $display("FAIL basic_done busy/underflow got %b/%b exp 0/0", a_busy, a_underflow); end
    step();
    checks++; if (a_done !== 1'b0 || a_load_ready !== 1'b1) begin errors++; $display("FAIL basic_after done/ready got %b/%b exp 0/1", a_done, a_load_ready); end
    a_en = 1'b0;
  endtask

  task automatic test_stride_underflow();
    b_load_valid = 1'b1; b_load_value = 4'd10; b_en = 1'b1;
    step();
    b_load_valid = 1'b0;
    checks++; if (b_countval !== 4'd10) begin errors++; $display("FAIL stride_accept countval got %0d exp 10", b_countval); end
    step();
    checks++; if (b_countval !== 4'd6) begin errors++; $display("FAIL stride_dec1 countval got %0d exp 6", b_countval); end
    step();
    checks++; if (b_countval !== 4'd2 || b_done !== 1'b0) begin errors++; $display("FAIL stride_dec2 countval/done got %0d/%b exp 2/0", b_countval, b_done); end
    step();
    checks++; if (b_countval !== 4'd0 || b_done !== 1'b1 || b_underflow !== 1'b1) begin errors++; $display("FAIL stride_done countval/done/uf got %0d/%b/%b exp 0/1/1", b_countval, b_done, b_underflow); end
    step();
    checks++; if (b_underflow !== 1'b1 || b_load_ready !== 1'b1) begin errors++; $display("FAIL stride_sticky uf/ready got %b/%b exp 1/1", b_underflow, b_load_ready); end
    b_load_valid = 1'b1; b_load_value = 4'd8;
    step();
    b_load_valid = 1'b0;
    checks++; if (b_countval !== 4'd8 || b_underflow !== 1'b0) begin errors++; $display("FAIL stride_reload countval/uf got %0d/%b exp 8/0", b_countval, b_underflow); end
    step();
    checks++; if (b_countval !== 4'd4) begin errors++; $display("FAIL stride_reload_dec countval got %0d exp 4", b_countval); end
    step();
    checks++; if (b_countval !== 4'd0 || b_done !== 1'b1 || b_underflow !== 1'b0) begin errors++; $display("FAIL stride_exact countval/done/uf got %0d/%b/%b exp 0/1/0", b_countval, b_done, b_underflow); end
    step();
    b_en = 1'b0;
  endtask

  task automatic test_enable_abort();
    a_load_valid = 1'b1; a_load_value = 4'd9; a_en = 1'b0;
    step();
    a_load_valid = 1'b0;
    checks++; if (a_countval !== 4'd9) begin errors++; $display("FAIL en_accept countval got %0d exp 9", a_countval); end
    a_en = 1'b1; step();
    checks++; if (a_countval !== 4'd8) begin errors++; $display("FAIL en_on1 countval got %0d exp 8", a_countval); end
    a_en = 1'b0; step();
    checks++; if (a_countval !== 4'd8) begin errors++; $display("FAIL en_off1 countval got %0d exp 8", a_countval); end
    a_en = 1'b1; step();
    checks++; if (a_countval !== 4'd7) begin errors++; $display("FAIL en_on2 countval got %0d exp 7", a_countval); end
    a_en = 1'b0; step();
    checks++; if (a_countval !== 4'd7 || a_busy !== 1'b1) begin errors++; $display("FAIL en_off2 countval/busy got %0d/%b exp 7/1", a_countval, a_busy); end
    a_en = 1'b1; a_abort = 1'b1; step();
    a_en = 1'b0; a_abort = 1'b0;
    checks++; if (a_countval !== 4'd0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_load_ready !== 1'b1) begin errors++; $display("FAIL abort countval/busy/done/ready got %0d/%b/%b/%b exp 0/0/0/1", a_countval, a_busy, a_done, a_load_ready); end
    step();
    checks++; if (a_done !== 1'b0 || a_load_ready !== 1'b1) begin errors++; $display("FAIL abort_after done/ready got %b/%b exp 0/1", a_done, a_load_ready); end
  endtask

  task automatic test_zero_and_held_load();
    a_load_valid = 1'b1; a_load_value = 4'd0;
    step();
    a_load_valid = 1'b0;
    checks++; if (a_done !== 1'b1 || a_busy !== 1'b0 || a_countval !== 4'd0) begin errors++; $display("FAIL zero_load done/busy/countval got %b/%b/%0d exp 1/0/0", a_done, a_busy, a_countval); end
    step();
    checks++; if (a_done !== 1'b0 || a_busy !== 1'b0 || a_load_ready !== 1'b1) begin errors++; $display("FAIL zero_after done/busy/ready got %b/%b/%b exp 0/0/1", a_done, a_busy, a_load_ready); end
    a_load_valid = 1'b1; a_load_value = 4'd4; a_en = 1'b0;
    step();
    a_load_value = 4'd2;
    checks++; if (a_countval !== 4'd4 || a_load_ready !== 1'b0) begin errors++; $display("FAIL held_accept countval/ready got %0d/%b exp 4/0", a_countval, a_load_ready); end
    step();
    checks++; if (a_countval !== 4'd4 || a_load_ready !== 1'b0) begin errors++; $display("FAIL held_ignored countval/ready got %0d/%b exp 4/0", a_countval, a_load_ready); end
    a_load_valid = 1'b0; a_en = 1'b1;
    step(); step(); step(); step();
    checks++; if (a_countval !== 4'd0 || a_done !== 1'b1) begin errors++; $display("FAIL held_done countval/done got %0d/%b exp 0/1", a_countval, a_done); end
    a_en = 1'b0;
    step();
  endtask

  task automatic test_max_load();
    a_load_valid = 1'b1; a_load_value = 4'd15; a_en = 1'b1;
    step();
    a_load_valid = 1'b0;
    checks++; if (a_countval !== 4'd15) begin errors++; $display("FAIL max_accept countval got %0d exp 15", a_countval); end
    for (int i = 14; i >= 1; i--) begin
      step();
      checks++; if (a_countval !== 4'(i) || a_done !== 1'b0) begin errors++; $display("FAIL max_count countval/done got %0d/%b exp %0d/0", a_countval, a_done, i); end
    end
    step();
    checks++; if (a_countval !== 4'd0 || a_done !== 1'b1 || a_underflow !== 1'b0) begin errors++; $display("FAIL max_done countval/done/uf got %0d/%b/%b exp 0/1/0", a_countval, a_done, a_underflow); end
    a_en = 1'b0;
    step();
  endtask

  task automatic test_reset_midrun();
    // Leave b idle with a sticky underflow so reset must clear it.
    b_load_valid = 1'b1; b_load_value = 4'd7; b_en = 1'b1;
    step();
    b_load_valid = 1'b0;
    step(); step();
    b_en = 1'b0;
    checks++; if (b_done !== 1'b1 || b_underflow !== 1'b1) begin errors++; $display("FAIL pre_reset_b done/uf got %b/%b exp 1/1", b_done, b_underflow); end
    a_load_valid = 1'b1; a_load_value = 4'd6; a_en = 1'b1;
    step();
    a_load_valid = 1'b0;
    step(); step(); step();
    checks++; if (a_countval !== 4'd3 || a_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_a countval/busy got %0d/%b exp 3/1", a_countval, a_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_countval !== 4'd0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_underflow !== 1'b0 || a_load_ready !== 1'b1) begin errors++; $display("FAIL async_reset_a countval/busy/done/uf/ready got %0d/%b/%b/%b/%b exp 0/0/0/0/1", a_countval, a_busy, a_done, a_underflow, a_load_ready); end
    checks++; if (b_underflow !== 1'b0 || b_load_ready !== 1'b1) begin errors++; $display("FAIL async_reset_b uf/ready got %b/%b exp 0/1", b_underflow, b_load_ready); end
    #2 rst_n = 1'b1;
    a_en = 1'b0;
    step();
    checks++; if (a_countval !== 4'd0 || a_done !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL post_reset countval/done/busy got %0d/%b/%b exp 0/0/0", a_countval, a_done, a_busy); end
  endtask

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    a_reload_en = 1'b1;
    a_load_valid = 1'b1; a_load_value = 4'd3; a_en = 1'b1;
    step();
    a_load_valid = 1'b0;
    checks++; if (a_countval !== 4'd3) begin errors++; $display("FAIL ar_accept countval got %0d exp 3", a_countval); end
    for (int p = 0; p < 2; p++) begin
      step();
      checks++; if (a_countval !== 4'd2) begin errors++; $display("FAIL ar_dec2 countval got %0d exp 2", a_countval); end
      step();
      checks++; if (a_countval !== 4'd1) begin errors++; $display("FAIL ar_dec1 countval got %0d exp 1", a_countval); end
      step();
      checks++; if (a_countval !== 4'd0 || a_done !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL ar_done countval/done/busy got %0d/%b/%b exp 0/1/0", a_countval, a_done, a_busy); end
      step();
      checks++; if (a_countval !== 4'd3 || a_done !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL ar_restart countval/done/busy got %0d/%b/%b exp 3/0/1", a_countval, a_done, a_busy); end
    end
    step(); step();
    a_reload_en = 1'b0;
    step();
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL ar_final_done got %b exp 1", a_done); end
    step();
    checks++; if (a_load_ready !== 1'b1 || a_busy !== 1'b0 || a_countval !== 4'd0) begin errors++; $display("FAIL ar_idle ready/busy/countval got %b/%b/%0d exp 1/0/0", a_load_ready, a_busy, a_countval); end
    a_en = 1'b0;
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    a_load_valid = 1'b0; a_load_value = '0; a_en = 1'b0; a_abort = 1'b0;
    b_load_valid = 1'b0; b_load_value = '0; b_en = 1'b0; b_abort = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    a_reload_en = 1'b0; b_reload_en = 1'b0;
`endif
    test_reset();
    test_basic_countdown();
    test_stride_underflow();
    test_enable_abort();
    test_zero_and_held_load();
    test_max_load();
    test_reset_midrun();
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
